// File: rtl/rans_dec.sv
`default_nettype none
// ============================================================================
// Module   : rans_dec
// Purpose  : Single-lane byte-oriented rANS decoder with a slot-to-symbol map.
//            Optional final-state check enabled by RANS_DEC_CHECK_EN.
// Revision : 1.0
// ============================================================================
module rans_dec #(
    parameter int RESOLUTION   = 10,
    parameter int SYMBOL_WIDTH = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    freq_wr_i,
    input  logic [SYMBOL_WIDTH-1:0] symb_i,
    input  logic [RESOLUTION:0]     freq_i,
    input  logic [RESOLUTION-1:0]   cum_freq_i,
    output logic                    cfg_ready_o,
    input  logic                    start_i,
    input  logic [15:0]             len_i,
    input  logic [7:0]              byte_i,
    input  logic                    byte_valid_i,
    output logic                    byte_ready_o,
    output logic [SYMBOL_WIDTH-1:0] symb_o,
    output logic                    symb_valid_o,
    input  logic                    symb_ready_i,
    output logic                    done_o,
    output logic                    err_o
);

    localparam int          M_SLOTS = 1 << RESOLUTION;
    localparam int          N_SYMS  = 1 << SYMBOL_WIDTH;
    localparam int          TW      = 2 * RESOLUTION + 1;
    localparam logic [31:0] L_BOUND = 32'h0080_0000;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FILL   = 3'd1,
        S_INIT   = 3'd2,
        S_LOOKUP = 3'd3,
        S_TABLE  = 3'd4,
        S_EMIT   = 3'd5,
        S_RENORM = 3'd6,
        S_DONE   = 3'd7
    } state_e;

    state_e                  state_q, state_d;
    logic [31:0]             x_q, x_d;
    logic [15:0]             count_q, count_d;
    logic [1:0]              init_cnt_q, init_cnt_d;
    logic [SYMBOL_WIDTH-1:0] fill_sym_q, fill_sym_d;
    logic [RESOLUTION-1:0]   fill_addr_q, fill_addr_d;
    logic [RESOLUTION:0]     fill_cnt_q, fill_cnt_d;
    logic [SYMBOL_WIDTH-1:0] symb_q, symb_d;
    logic                    cfg_ready_q, cfg_ready_d;
    logic                    byte_ready_q, byte_ready_d;
    logic                    symb_valid_q, symb_valid_d;
    logic                    done_q, done_d;
    logic [SYMBOL_WIDTH-1:0] slot_rd_q, slot_rd_d;
    logic [TW-1:0]           tab_rd_q, tab_rd_d;

    logic [TW-1:0]           table_mem [N_SYMS];
    logic [SYMBOL_WIDTH-1:0] slot_mem  [M_SLOTS];

    logic                    byte_hs, symb_hs, table_we, slot_we;
    logic [RESOLUTION:0]     dec_freq;
    logic [RESOLUTION-1:0]   dec_cum;
    logic [32:0]             prod;
    logic [31:0]             x_emit, x_shift;

    assign byte_hs  = byte_valid_i & byte_ready_q;
    assign symb_hs  = symb_valid_q & symb_ready_i;
    assign table_we = (state_q == S_IDLE) & freq_wr_i;
    assign slot_we  = (state_q == S_FILL);
    assign dec_freq = tab_rd_q[TW-1:RESOLUTION];
    assign dec_cum  = tab_rd_q[RESOLUTION-1:0];

    // (RESOLUTION+1) x (32-RESOLUTION) always fits 33 bits; result keeps the low 32.
    assign prod    = 33'(dec_freq) * 33'(x_q >> RESOLUTION);
    assign x_emit  = prod[31:0] + 32'(x_q[RESOLUTION-1:0]) - 32'(dec_cum);
    assign x_shift = {x_q[23:0], byte_i};

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        count_d     = count_q;
        init_cnt_d  = init_cnt_q;
        fill_sym_d  = fill_sym_q;
        fill_addr_d = fill_addr_q;
        fill_cnt_d  = fill_cnt_q;
        symb_d      = symb_q;
        slot_rd_d   = slot_rd_q;
        tab_rd_d    = tab_rd_q;

        case (state_q)
            S_IDLE: begin
                if (freq_wr_i) begin
                    fill_sym_d  = symb_i;
                    fill_addr_d = cum_freq_i;
                    fill_cnt_d  = freq_i;
                    if (freq_i != '0) begin
                        state_d = S_FILL;
                    end
                end else if (start_i) begin
                    count_d    = len_i;
                    init_cnt_d = 2'd0;
                    state_d    = (len_i == 16'd0) ? S_DONE : S_INIT;
                end
            end
            S_FILL: begin
                fill_addr_d = fill_addr_q + 1'b1;
                fill_cnt_d  = fill_cnt_q - 1'b1;
                if (fill_cnt_q == {{RESOLUTION{1'b0}}, 1'b1}) begin
                    state_d = S_IDLE;
                end
            end
            S_INIT: begin
                if (byte_hs) begin
                    x_d        = x_shift;
                    init_cnt_d = init_cnt_q + 1'b1;
                    if (init_cnt_q == 2'd3) begin
                        state_d = S_LOOKUP;
                    end
                end
            end
            S_LOOKUP: begin
                slot_rd_d = slot_mem[x_q[RESOLUTION-1:0]];
                state_d   = S_TABLE;
            end
            S_TABLE: begin
                tab_rd_d = table_mem[slot_rd_q];
                symb_d   = slot_rd_q;
                state_d  = S_EMIT;
            end
            S_EMIT: begin
                if (symb_hs) begin
                    x_d     = x_emit;
                    count_d = count_q - 16'd1;
                    if (x_emit < L_BOUND) begin
                        state_d = S_RENORM;
                    end else if (count_q == 16'd1) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_LOOKUP;
                    end
                end
            end
            S_RENORM: begin
                if (byte_hs) begin
                    x_d = x_shift;
                    if (x_shift >= L_BOUND) begin
                        state_d = (count_q == 16'd0) ? S_DONE : S_LOOKUP;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Handshake outputs are registered decodes of the next state.
        cfg_ready_d  = (state_d == S_IDLE);
        byte_ready_d = (state_d == S_INIT) || (state_d == S_RENORM);
        symb_valid_d = (state_d == S_EMIT);
        done_d       = (state_d == S_DONE);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            x_q          <= '0;
            count_q      <= '0;
            init_cnt_q   <= '0;
            fill_sym_q   <= '0;
            fill_addr_q  <= '0;
            fill_cnt_q   <= '0;
            symb_q       <= '0;
            cfg_ready_q  <= 1'b1;
            byte_ready_q <= 1'b0;
            symb_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            count_q      <= count_d;
            init_cnt_q   <= init_cnt_d;
            fill_sym_q   <= fill_sym_d;
            fill_addr_q  <= fill_addr_d;
            fill_cnt_q   <= fill_cnt_d;
            symb_q       <= symb_d;
            cfg_ready_q  <= cfg_ready_d;
            byte_ready_q <= byte_ready_d;
            symb_valid_q <= symb_valid_d;
            done_q       <= done_d;
        end
    end

    // RAMs and their read registers survive reset.
    always_ff @(posedge clk_i) begin
        slot_rd_q <= slot_rd_d;
        tab_rd_q  <= tab_rd_d;
        if (table_we) begin
            table_mem[symb_i] <= {freq_i, cum_freq_i};
        end
        if (slot_we) begin
            slot_mem[fill_addr_q] <= fill_sym_q;
        end
    end

`ifdef RANS_DEC_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if ((state_q == S_IDLE) && !freq_wr_i && start_i) begin
            err_d = 1'b0;
        end else if (state_q == S_DONE) begin
            err_d = (x_q != L_BOUND);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign cfg_ready_o  = cfg_ready_q;
    assign byte_ready_o = byte_ready_q;
    assign symb_o       = symb_q;
    assign symb_valid_o = symb_valid_q;
    assign done_o       = done_q;

endmodule
`default_nettype wire

// File: doc/rans_dec.md
# rans_dec

Single-lane byte-oriented rANS decoder, the receive-side counterpart of the `rans` encoder lane. It loads the same per-symbol frequency/cumulative-frequency table that the encoder receives and builds an internal slot-to-symbol map from it. It then consumes a byte stream presented in decode order, MSB of the initial state first, and emits decoded symbols over a valid/ready handshake. The block sits behind the stream reader and ahead of the symbol sink. One instance corresponds to one interleaved encoder lane.

## Interface
- `RESOLUTION`, 10: probability scale bits; M = 2^RESOLUTION slots.
- `SYMBOL_WIDTH`, 8: symbol bits; the table holds 2^SYMBOL_WIDTH entries.
- `clk_i`  in  1  single clock.
- `rst_ni`  in  1  reset, synchronous, active-low.
- `freq_wr_i`  in  1  table write strobe; accepted only when `cfg_ready_o`=1.
- `symb_i`  in  SYMBOL_WIDTH  table write address (symbol).
- `freq_i`  in  RESOLUTION+1  symbol frequency, 0..M.
- `cum_freq_i`  in  RESOLUTION  symbol cumulative frequency.
- `cfg_ready_o`  out  1  high in IDLE only.
- `start_i`  in  1  begin decode; sampled in IDLE.
- `len_i`  in  16  number of symbols to decode; latched on `start_i`.
- `byte_i`  in  8  compressed byte.
- `byte_valid_i`  in  1  /  `byte_ready_o`  out  1  input handshake.
- `symb_o`  out  SYMBOL_WIDTH  decoded symbol.
- `symb_valid_o`  out  1  /  `symb_ready_i`  in  1  output handshake.
- `done_o`  out  1  one-cycle pulse when decode completes.
- `err_o`  out  1  final-state mismatch flag; see Configuration.

## Operation
- State x is 32 bits. Lower bound L = 2^23; valid range [L, 2^31).
- Symbol table is a synchronous-read RAM of {freq, cum} entries. Slot map is a synchronous-read RAM of M × SYMBOL_WIDTH bits. Neither RAM is cleared by reset.
- FSM states: IDLE, FILL, INIT, LOOKUP, TABLE, EMIT, RENORM, DONE.
- IDLE, `freq_wr_i`=1:
  - Write {freq_i, cum_freq_i} to table[symb_i].
  - Latch symb_i, cum_freq_i and freq_i as the fill counter.
  - If freq_i≠0, go to FILL; otherwise stay in IDLE.
- FILL: write the symbol to slot[cum+k] for k = 0..freq-1, one slot per cycle, then return to IDLE.
- IDLE, `start_i`=1 (lower priority than `freq_wr_i`):
  - Latch len_i.
  - If len_i=0, go to DONE.
  - Otherwise go to INIT.
- INIT: accept 4 bytes, x = (x<<8) | byte each, big-endian, then go to LOOKUP.
- LOOKUP: read slot[x & (M-1)].
- TABLE: read table[s].
- EMIT:
  - Drive `symb_o`=s with `symb_valid_o`=1 and hold until `symb_ready_i`.
  - On handshake: x ← freq·(x>>RESOLUTION) + (x & (M-1)) − cum; decrement the remaining count.
- After EMIT:
  - x' < L → RENORM.
  - Else count=0 → DONE.
  - Else → LOOKUP.
- RENORM: accept one byte per handshake, x = (x<<8) | byte, until x ≥ L. Then go to DONE if count=0, otherwise to LOOKUP.
- DONE: pulse `done_o`, update `err_o`, return to IDLE.
- Arithmetic:
  - Product is (RESOLUTION+1) × (32−RESOLUTION) bits, truncated to 32.
  - Well-formed streams never overflow; no saturation is applied.
- `freq_wr_i` outside IDLE and `start_i` outside IDLE are ignored.
- Slot addressing cum+k wraps mod M. Overlapping fills: the last write wins.

## Timing
- Reset values: `cfg_ready_o`=1, `byte_ready_o`=0, `symb_valid_o`=0, `symb_o`=0, `done_o`=0, `err_o`=0, FSM=IDLE, x=0, count=0.
- Reset mid-operation returns to IDLE on the next edge. Partial state is discarded; the RAMs are retained.
- `byte_ready_o`=1 exactly in INIT and RENORM. It is registered from state, not dependent on `byte_valid_i`.
- Latencies:
  - Table write: 1 + freq cycles until `cfg_ready_o` is high again.
  - `start_i` to first `symb_valid_o`: 4 byte handshakes + 2 cycles.
  - Steady state with no renorm and no stalls: 1 symbol per 3 cycles (LOOKUP, TABLE, EMIT).
  - Each renorm byte adds at least 1 cycle.
- `symb_o` is stable while `symb_valid_o`=1 and `symb_ready_i`=0.
- `done_o` rises one cycle after the final EMIT handshake, or after the final RENORM byte if renorm was needed.

## Configuration
- `RANS_DEC_CHECK_EN` defined:
  - In DONE, `err_o` ← (x ≠ L).
  - `err_o` holds until the next `start_i`, which clears it.
- Not defined: `err_o` is tied to 0 and the comparator is absent.

## Test plan
- Single-symbol table, RESOLUTION=10: symb 0x41 with freq 1024, cum 0.
  - After the write, `cfg_ready_o`=0 for 1024 cycles.
  - Start with len=5, bytes 00 80 00 00 → symbols 41 ×5, no further bytes consumed, `done_o` pulse, `err_o`=0.
- Two-symbol table: s0 with freq 512/cum 0, s1 with freq 512/cum 512.
  - Init bytes 00 80 00 00 → s0; x=0x400000; RENORM takes byte 00 → x=0x40000000.
  - Next symbol is s0 with x=0x20000000.
- Backpressure: hold `symb_ready_i`=0 for 10 cycles mid-stream → `symb_o` stable, no byte accepted, decoded sequence unchanged.
- len_i=0 → `done_o` 1 cycle after DONE entry, `byte_ready_o` never asserted.
- Reset asserted in RENORM:
  - Outputs return to reset values.
  - A fresh start with the same stream decodes correctly without reloading the table.
- `RANS_DEC_CHECK_EN`, single-symbol table:
  - Init bytes 00 80 00 01 → `err_o`=1.
  - Init bytes 00 80 00 00 → `err_o`=0.
